// File: rtl/bvudiv_bvsle_checker.sv
// Sequential checker for (x bvudiv s) bvsle t.
// Restoring divider, one quotient bit per cycle, then a signed compare.
module bvudiv_bvsle_checker #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             sat
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        CMP,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] x_q, s_q, t_q;
    logic [WIDTH-1:0] r_q, q_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             sat_q;
    logic             in_ready_q, out_valid_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;
    logic             ge;

    // r_q[WIDTH-1] is the carry bit of the shifted remainder
    always_comb begin
        r_sh = {r_q[WIDTH-2:0], x_q[cnt_q]};
        ge   = r_q[WIDTH-1] | (r_sh >= s_q);
        r_d  = ge ? (r_sh - s_q) : r_sh;
        q_d  = {q_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            s_q         <= '0;
            t_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q        <= x;
                        s_q        <= s;
                        t_q        <= t;
                        r_q        <= '0;
                        q_q        <= '0;
                        cnt_q      <= CW'(WIDTH - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= DIV;
                    end
                end
                DIV: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    if (cnt_q == '0) begin
                        state_q <= CMP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                CMP: begin
                    sat_q       <= $signed(q_q) <= $signed(t_q);
                    quot_q      <= q_q;
                    rem_q       <= r_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_bvudiv_bvsle_checker.sv
// Bench for bvudiv_bvsle_checker: directed steps, exhaustive sweep
// and random transactions against an arithmetic reference.
module tb_bvudiv_bvsle_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x, s, t;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quot, rem;
    logic         sat;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    bvudiv_bvsle_checker #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .s        (s),
        .t        (t),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot     (quot),
        .rem      (rem),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sval(input int v);
        return (v >= 2 ** (W - 1)) ? v - 2 ** W : v;
    endfunction

    // SMT-LIB bvudiv / bvurem plus two's-complement compare
    task automatic ref_model(input logic [W-1:0] a, b, c,
                             output logic [W-1:0] eq, er,
                             output logic es);
        if (b == 0) begin
            eq = W'(2 ** W - 1);
            er = a;
        end else begin
            eq = W'(int'(a) / int'(b));
            er = W'(int'(a) % int'(b));
        end
        es = sval(int'(eq)) <= sval(int'(c));
    endtask

    task automatic scramble();
        in_valid = 1'($urandom);
        x = W'($urandom);
        s = W'($urandom);
        t = W'($urandom);
    endtask

    // Called at a falling edge with the DUT idle; returns one falling
    // edge after the output handshake with in_valid low.
    task automatic txn(input logic [W-1:0] a, b, c, input int hold);
        int cyc;
        logic [W-1:0] eq, er;
        logic es;
        ref_model(a, b, c, eq, er, es);
        x = a;
        s = b;
        t = c;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        n_vec++;
        chk("accept_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        while (!out_valid && cyc < 30) begin
            scramble();
            @(negedge clk);
            cyc++;
        end
        chk("out_valid_seen", out_valid, 1);
        chk("latency", cyc, W + 2);
        for (int i = 0; i < hold; i++) begin
            chk("hold_quot", quot, eq);
            chk("hold_rem", rem, er);
            chk("hold_sat", sat, es);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            scramble();
            in_valid = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("quot", quot, eq);
        chk("rem", rem, er);
        chk("sat", sat, es);
        chk("done_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        s = '0;
        t = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_sat", sat, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // nominal
        txn(4'd13, 4'd3, 4'd5, 0);
        chk("nominal_quot", quot, 4);
        chk("nominal_rem", rem, 1);
        chk("nominal_sat", sat, 1);

        // divide by zero
        txn(4'd9, 4'd0, 4'd8, 0);
        chk("dz_quot", quot, 15);
        chk("dz_rem", rem, 9);
        chk("dz_sat_m8", sat, 0);
        txn(4'd9, 4'd0, 4'd15, 0);
        chk("dz_sat_m1", sat, 1);

        // signed wrap of the quotient
        txn(4'd8, 4'd1, 4'd7, 0);
        chk("wrap_quot", quot, 8);
        chk("wrap_sat", sat, 1);
        txn(4'd7, 4'd1, 4'd8, 0);
        chk("wrap_sat2", sat, 0);

        // backpressure
        txn(4'd14, 4'd4, 4'd2, 3);

        // reset in the second DIV cycle
        x = 4'd15;
        s = 4'd2;
        t = 4'd0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        n_vec++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quot", quot, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            chk("midrst_no_pulse", out_valid, 0);
        end
        txn(4'd15, 4'd2, 4'd7, 0);
        chk("midrst_fresh_quot", quot, 7);
        chk("midrst_fresh_rem", rem, 1);
        chk("midrst_fresh_sat", sat, 1);

        // reset while DONE waits
        x = 4'd5;
        s = 4'd1;
        t = 4'd0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n_vec++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (W + 1) @(negedge clk);
        chk("donerst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("donerst_out_valid", out_valid, 0);
        chk("donerst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // exhaustive back-to-back sweep
        for (int a = 0; a < 2 ** W; a++)
            for (int b = 0; b < 2 ** W; b++)
                for (int c = 0; c < 2 ** W; c++)
                    txn(W'(a), W'(b), W'(c), 0);

        // random operands with random backpressure
        for (int i = 0; i < 200; i++)
            txn(W'($urandom), W'($urandom), W'($urandom),
                int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
